// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready on both sides.
// S1 holds the accepted operands, S2 holds the presented result. The
// result of each operation is also captured in acc_reg so that an acc=1
// operation can chain on the immediately preceding one without a stall.
module alu_pipe #(
    parameter int WIDTH  = 8,
    parameter bit ACC_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    input  logic             acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             sgn
);

    typedef enum logic [1:0] {
        OP_SHADD = 2'd0,
        OP_SCADD = 2'd1,
        OP_NEG   = 2'd2,
        OP_ABS3  = 2'd3
    } op_e;

    // Stage 1: accepted operand set
    logic             s1_v;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_sel;
    logic             s1_acc;

    // Stage 2: presented result
    logic             s2_v;
    logic [WIDTH-1:0] s2_out;
    logic             s2_zero;
    logic             s2_sgn;

    logic [WIDTH-1:0] acc_reg;

    // Combinational results from S1
    logic             s1_adv;
    logic             s1_load;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] y3;
    logic [WIDTH-1:0] res;
    logic             res_sgn;

    // Handshake: out_ready reaches in_ready combinationally; in_valid never does.
    always_comb begin
        s1_adv   = s1_v && (!s2_v || out_ready);
        in_ready = !rst && (!s1_v || s1_adv);
        s1_load  = in_valid && in_ready;
    end

    // Datapath: operand select, the four operations and their flags.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case can leave a variable unassigned and infer a latch.
        a1      = (ACC_EN && s1_acc) ? acc_reg : s1_a;
        y3      = a1 + (a1 << 1) - s1_b;
        res     = '0;
        res_sgn = 1'b0;
        unique case (s1_sel)
            OP_SHADD: res = (a1 << 2) + (s1_b >> 2);
            OP_SCADD: res = a1 + (s1_b << 1);
            OP_NEG:   res = (~s1_b) + WIDTH'(1);
            OP_ABS3:  res = y3[WIDTH-1] ? (~y3) + WIDTH'(1) : y3;
            default:  res = '0;
        endcase
        // For the absolute-value op the flag reports the sign before abs().
        res_sgn = (s1_sel == OP_ABS3) ? y3[WIDTH-1] : res[WIDTH-1];
    end

    // Stage 1 register: load on acceptance, empty when it advances unreplaced.
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            s1_v   <= 1'b0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_sel <= OP_SHADD;
            s1_acc <= 1'b0;
        end else if (s1_load) begin
            s1_v   <= 1'b1;
            s1_a   <= a;
            s1_b   <= b;
            s1_sel <= op_e'(sel);
            s1_acc <= acc;
        end else if (s1_adv) begin
            s1_v   <= 1'b0;
        end
    end

    // Stage 2 register and accumulator: both capture the S1 result as it advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v    <= 1'b0;
            s2_out  <= '0;
            s2_zero <= 1'b0;
            s2_sgn  <= 1'b0;
            acc_reg <= '0;
        end else if (s1_adv) begin
            s2_v    <= 1'b1;
            s2_out  <= res;
            s2_zero <= (res == '0);
            s2_sgn  <= res_sgn;
            acc_reg <= res;
        end else if (s2_v && out_ready) begin
            s2_v    <= 1'b0;
        end
    end

    assign out_valid = s2_v;
    assign out       = s2_out;
    assign zero      = s2_zero;
    assign sgn       = s2_sgn;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed, table-driven bench for alu_pipe (WIDTH=8 with
// accumulator, WIDTH=16 with ACC_EN=0) plus hand-written multi-cycle sequences.
module tb_alu_pipe;

    logic clk = 1'b0;
    logic rst;

    // WIDTH=8 instance signals
    logic       in_valid, in_ready, acc, out_valid, out_ready, zero, sgn;
    logic [7:0] a, b, out;
    logic [1:0] sel;

    // WIDTH=16 instance signals
    logic        in_valid16, in_ready16, acc16, out_valid16, out_ready16, zero16, sgn16;
    logic [15:0] a16, b16, out16;
    logic [1:0]  sel16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8), .ACC_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .acc(acc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .zero(zero), .sgn(sgn)
    );

    alu_pipe #(.WIDTH(16), .ACC_EN(1'b0)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .sel(sel16), .acc(acc16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .out(out16), .zero(zero16), .sgn(sgn16)
    );

    typedef struct {
        string      name;
        logic [1:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] out;
        logic       zero;
        logic       sgn;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] s, input logic [7:0] va, input logic [7:0] vb,
                         input logic vacc);
        in_valid = 1'b1;
        sel      = s;
        a        = va;
        b        = vb;
        acc      = vacc;
        #1;
    endtask

    // One isolated 16-bit operation, checked two edges after it is offered.
    task automatic op16(input string name, input logic [1:0] s, input logic [15:0] va,
                        input logic [15:0] vb, input logic vacc, input logic [15:0] e_out,
                        input logic e_zero, input logic e_sgn);
        in_valid16 = 1'b1;
        sel16 = s; a16 = va; b16 = vb; acc16 = vacc;
        #1;
        check({name, " in_ready"}, 32'(in_ready16), 32'd1);
        tick();
        in_valid16 = 1'b0;
        tick();
        check({name, " out_valid"}, 32'(out_valid16), 32'd1);
        check({name, " out"}, 32'(out16), 32'(e_out));
        check({name, " zero"}, 32'(zero16), 32'(e_zero));
        check({name, " sgn"}, 32'(sgn16), 32'(e_sgn));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"shadd 41/0f",  2'd0, 8'h41, 8'h0F, 8'h07, 1'b0, 1'b0};
        vecs[1]  = '{"scadd f0/0c",  2'd1, 8'hF0, 8'h0C, 8'h08, 1'b0, 1'b0};
        vecs[2]  = '{"neg 01",       2'd2, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b1};
        vecs[3]  = '{"neg 80",       2'd2, 8'h00, 8'h80, 8'h80, 1'b0, 1'b1};
        vecs[4]  = '{"neg 00",       2'd2, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{"abs3 02/0a",   2'd3, 8'h02, 8'h0A, 8'h04, 1'b0, 1'b1};
        vecs[6]  = '{"abs3 10/05",   2'd3, 8'h10, 8'h05, 8'h2B, 1'b0, 1'b0};
        vecs[7]  = '{"abs3 00/80",   2'd3, 8'h00, 8'h80, 8'h80, 1'b0, 1'b1};
        vecs[8]  = '{"scadd ff/80",  2'd1, 8'hFF, 8'h80, 8'hFF, 1'b0, 1'b1};
        vecs[9]  = '{"shadd ff/ff",  2'd0, 8'hFF, 8'hFF, 8'h3B, 1'b0, 1'b0};
        vecs[10] = '{"abs3 55/ff",   2'd3, 8'h55, 8'hFF, 8'h00, 1'b1, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; sel = '0; acc = 1'b0; out_ready = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; sel16 = '0; acc16 = 1'b0; out_ready16 = 1'b1;
        #1;
        check("in_ready during reset", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out", 32'(out), 32'd0);
        check("reset zero", 32'(zero), 32'd0);
        check("reset sgn", 32'(sgn), 32'd0);
        check("in_ready after reset", 32'(in_ready), 32'd1);

        // Isolated operations with out_ready held high.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].sel, vecs[i].a, vecs[i].b, 1'b0);
            check({vecs[i].name, " in_ready"}, 32'(in_ready), 32'd1);
            tick();
            in_valid = 1'b0;
            check({vecs[i].name, " latency"}, 32'(out_valid), 32'd0);
            tick();
            check({vecs[i].name, " out_valid"}, 32'(out_valid), 32'd1);
            check({vecs[i].name, " out"}, 32'(out), 32'(vecs[i].out));
            check({vecs[i].name, " zero"}, 32'(zero), 32'(vecs[i].zero));
            check({vecs[i].name, " sgn"}, 32'(sgn), 32'(vecs[i].sgn));
            tick();
        end
        check("idle after table", 32'(out_valid), 32'd0);

        // Accumulator chaining: 1+2=3, 3+2=5, 5+4=9 on consecutive cycles.
        drive(2'd1, 8'h01, 8'h01, 1'b0);
        tick();
        check("chain latency", 32'(out_valid), 32'd0);
        drive(2'd1, 8'hAA, 8'h01, 1'b1);
        tick();
        check("chain r0 valid", 32'(out_valid), 32'd1);
        check("chain r0", 32'(out), 32'h03);
        drive(2'd1, 8'hAA, 8'h02, 1'b1);
        tick();
        in_valid = 1'b0;
        check("chain r1 valid", 32'(out_valid), 32'd1);
        check("chain r1", 32'(out), 32'h05);
        tick();
        check("chain r2 valid", 32'(out_valid), 32'd1);
        check("chain r2", 32'(out), 32'h09);
        tick();
        check("chain drained", 32'(out_valid), 32'd0);

        // Back-pressure: two accepted, third waits until S1 frees.
        out_ready = 1'b0;
        drive(2'd1, 8'h10, 8'h01, 1'b0);
        check("bp op0 in_ready", 32'(in_ready), 32'd1);
        tick();
        drive(2'd1, 8'h20, 8'h02, 1'b0);
        check("bp op1 in_ready", 32'(in_ready), 32'd1);
        tick();
        drive(2'd1, 8'h7F, 8'h7F, 1'b0);
        check("bp full in_ready", 32'(in_ready), 32'd0);
        check("bp out held", 32'(out), 32'h12);
        tick();
        check("bp still full", 32'(in_ready), 32'd0);
        check("bp out stable", 32'(out), 32'h12);
        check("bp out_valid", 32'(out_valid), 32'd1);
        tick();
        check("bp out stable 2", 32'(out), 32'h12);
        drive(2'd1, 8'h30, 8'h03, 1'b0);
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp r1", 32'(out), 32'h24);
        tick();
        check("bp r2", 32'(out), 32'h36);
        check("bp r2 valid", 32'(out_valid), 32'd1);
        tick();
        check("bp drained", 32'(out_valid), 32'd0);

        // Reset mid-flight: both stages full, acc_reg nonzero.
        out_ready = 1'b0;
        drive(2'd1, 8'h05, 8'h01, 1'b0);
        tick();
        drive(2'd1, 8'h06, 8'h01, 1'b0);
        tick();
        in_valid = 1'b0;
        check("pre-reset full", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("mid reset in_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post reset out_valid", 32'(out_valid), 32'd0);
        check("post reset in_ready", 32'(in_ready), 32'd1);
        drive(2'd1, 8'h55, 8'h01, 1'b1);
        tick();
        in_valid = 1'b0;
        check("post reset no stale", 32'(out_valid), 32'd0);
        tick();
        check("post reset acc valid", 32'(out_valid), 32'd1);
        check("post reset acc out", 32'(out), 32'h02);
        tick();

        // Width generality on the 16-bit instance (accumulator disabled).
        op16("w16 abs3 1/5", 2'd3, 16'h0001, 16'h0005, 1'b0, 16'h0002, 1'b0, 1'b1);
        op16("w16 shadd 4000", 2'd0, 16'h4000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
        op16("w16 acc ignored", 2'd1, 16'h0003, 16'h0001, 1'b1, 16'h0005, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Pipelined, parametrised successor to the team's 8-bit four-operation ALU. It keeps the same four operations (shift-add, scaled add, negate, absolute 3a−b) and adds several capabilities:
- configurable datapath width;
- a two-stage registered pipeline with valid/ready handshakes on both sides;
- an accumulator mode that chains results;
- status flags.

It sits between an operand source (sequencer or FIFO) and a result consumer. Back-pressure flows upstream through `in_ready`.

## Interface
- `WIDTH`, default 8: datapath width in bits; must be ≥ 3.
- `ACC_EN`, default 1: 1 enables accumulator substitution; 0 ties the effective `acc` to 0.

- `clk`, input, 1: sole clock; all state updates on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, 1: an operand set is presented.
- `in_ready`, output, 1: the block accepts the operand set this cycle.
- `a`, input, WIDTH: operand A.
- `b`, input, WIDTH: operand B.
- `sel`, input, 2: operation select.
- `acc`, input, 1: use the accumulator register in place of `a`.
- `out_valid`, output, 1: a result is presented.
- `out_ready`, input, 1: the consumer takes the result this cycle.
- `out`, output, WIDTH: the result.
- `zero`, output, 1: `out` == 0.
- `sgn`, output, 1: for `sel`=3, the sign bit of the raw 3a−b before the absolute value; otherwise `out[WIDTH-1]`.

## Operation
- A transfer occurs on an edge where `valid`&&`ready` on the respective side.
- Stage 1 (S1) registers `a`, `b`, `sel` and `acc`. It holds the flag `s1_v`.
- Stage 2 (S2) registers `out`, `zero` and `sgn`. It holds the flag `s2_v`, which drives `out_valid`.
- Effective operand A1 = (`acc` && `ACC_EN`) ? `acc_reg` : S1.a.
- All arithmetic is modulo 2^WIDTH. Shifts are logical, zero-filled.
  - `sel`=0: (A1<<2) + (b>>2).
  - `sel`=1: A1 + (b<<1).
  - `sel`=2: (~b)+1. Negating 0 gives 0. Negating 2^(WIDTH-1) gives 2^(WIDTH-1).
  - `sel`=3: y = 3·A1 − b, truncated to WIDTH. Result = y[WIDTH-1] ? (~y)+1 : y, so y = 2^(WIDTH-1) yields 2^(WIDTH-1).
- The result is computed combinationally from S1 and loaded into S2 when S1 advances.
- `acc_reg` loads the same result on the same edge. Consequently an `acc`=1 operation in S1 always sees the result of the immediately preceding accepted operation, with no stall.
- `acc_reg` is updated by every operation regardless of the `acc` bit.
- Handshake:
  - `s1_adv` = `s1_v` && (!`s2_v` || `out_ready`).
  - `in_ready` = !`rst` && (!`s1_v` || `s1_adv`).
  - Combinational paths are `out_ready` → `in_ready` only. There is no `in_valid` → `in_ready` path.
- Each edge:
  - If `s1_adv`, S2 loads.
  - Else if `out_valid` && `out_ready`, `s2_v` clears.
  - S1 loads when `in_valid` && `in_ready`; otherwise `s1_v` clears if `s1_adv`.
- While `out_valid`=1 and `out_ready`=0: `out`, `zero` and `sgn` are held stable.
- Results leave in acceptance order.
- Operands are sampled only at acceptance. Input changes while `in_ready`=0 have no effect.

## Timing
- Reset values on the edge with `rst`=1: `s1_v`=0, `s2_v`=0, `out_valid`=0, `out`=0, `zero`=0, `sgn`=0, `acc_reg`=0.
  - `in_ready`=0 during the reset cycle and 1 on the first cycle after.
- Reset mid-operation discards both stages. No result from before reset is ever presented.
- Latency: an operand accepted at edge N appears with `out_valid`=1 after edge N+1, unstalled.
- Throughput: 1 operation/cycle while `out_ready`=1.
- Capacity: 2 operations in flight. With `out_ready`=0, `in_ready` falls after the second acceptance.
- Simultaneous S2 drain and S1 advance in the same cycle: S2 reloads with no bubble.

## Test plan
- Direct operations, WIDTH=8, `acc`=0:
  - `sel`=0, a=0x41, b=0x0F → `out`=0x07.
  - `sel`=1, a=0xF0, b=0x0C → `out`=0x08.
  - `sel`=2, b=0x01 → 0xFF; b=0x80 → 0x80; b=0x00 → 0x00, `zero`=1.
- Absolute value, `sel`=3:
  - a=0x02, b=0x0A → `out`=0x04, `sgn`=1.
  - a=0x10, b=0x05 → `out`=0x2B, `sgn`=0.
  - a=0x00, b=0x80 → `out`=0x80.
- Accumulator chaining: back-to-back `sel`=1 {a=1, b=1, `acc`=0}, then {b=1, `acc`=1}, then {b=2, `acc`=1}, with `out_ready`=1 → `out` sequence 0x03, 0x05, 0x09 on consecutive cycles; first result 2 cycles after acceptance.
- Back-pressure: hold `out_ready`=0 and offer 3 operations → exactly 2 accepted, `in_ready`=0 afterward, `out` stable. Release `out_ready` → results in order, third accepted the same cycle S1 frees.
- Reset mid-flight: both stages valid, `acc_reg`≠0, assert `rst` one cycle → next cycle `out_valid`=0, `in_ready`=1. A subsequent `acc`=1, `sel`=1, b=1 → `out`=0x02.
- Width generality: WIDTH=16, `sel`=3, a=0x0001, b=0x0005 → `out`=0x0002, `sgn`=1. `sel`=0, a=0x4000 → `out`=0x0000, `zero`=1.
